// File: rtl/hssl_reg_wr_arbiter_if.sv
// Requester handshake and register-bank write bus for hssl_reg_wr_arbiter.
// The slave modport is the arbiter; the master modport is the requester/bank side.
`ifndef RADDR_BITS
`define RADDR_BITS 8
`endif

interface hssl_reg_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RADDR_BITS = `RADDR_BITS
);
    logic [NUM_REQ*RADDR_BITS-1:0] req_addr_in;
    logic [NUM_REQ*32-1:0]         req_data_in;
    logic [NUM_REQ-1:0]            req_vld_in;
    logic [NUM_REQ-1:0]            req_rdy_out;
    logic [RADDR_BITS-1:0]         reg_addr_out;
    logic [31:0]                   reg_wdata_out;
    logic                          reg_en_out;
    logic [NUM_REQ-1:0]            grant_out;

    modport master (
        output req_addr_in, req_data_in, req_vld_in,
        input  req_rdy_out, reg_addr_out, reg_wdata_out, reg_en_out, grant_out
    );

    modport slave (
        input  req_addr_in, req_data_in, req_vld_in,
        output req_rdy_out, reg_addr_out, reg_wdata_out, reg_en_out, grant_out
    );
endinterface

// File: rtl/hssl_reg_wr_arbiter.sv
// hssl_reg_wr_arbiter: round-robin, burst-bounded sharing of the register-bank
// packet write port between NUM_REQ requesters. One registered write per cycle.
// Optional feature macro: REG_ARB_WAIT_CNT_EN (per-requester 16-bit wait counters).
`ifndef RADDR_BITS
`define RADDR_BITS 8
`endif

module hssl_reg_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RADDR_BITS = `RADDR_BITS,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stop_in,
    hssl_reg_wr_arbiter_if.slave    bus,
    output logic [NUM_REQ*16-1:0]   wait_cnt_out
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    reg_en_q, reg_en_d;
    logic [RADDR_BITS-1:0]   reg_addr_q, reg_addr_d;
    logic [31:0]             reg_wdata_q, reg_wdata_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;

    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        search_start;
    logic [NUM_REQ-1:0]      rdy_c;

    // Index following idx, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // First valid requester scanning upward from start with wrap; MSB = found.
    function automatic logic [IDX_W:0] first_valid(input logic [NUM_REQ-1:0] vld,
                                                   input logic [IDX_W-1:0]   start);
        logic [IDX_W:0] res;
        int unsigned    idx;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(start) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!res[IDX_W] && vld[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    // Arbitration: burst continuation, round-robin handover, stop handling.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        search_start = rr_ptr_q;
        win_found    = 1'b0;
        win_idx      = owner_q;
        if (reset) begin
            state_d = IDLE;
        end else if (stop_in) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
        end else if (state_q == BURST && bus.req_vld_in[owner_q] && burst_cnt_q < BURST_LAST) begin
            win_found   = 1'b1;
            win_idx     = owner_q;
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
            if (state_q == BURST) begin
                search_start = next_idx(owner_q);
                rr_ptr_d     = search_start;
            end
            {win_found, win_idx} = first_valid(bus.req_vld_in, search_start);
            burst_cnt_d = '0;
            if (win_found) begin
                state_d = BURST;
                owner_d = win_idx;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Accept strobe and next registered write payload.
    always_comb begin
        rdy_c       = '0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        if (win_found) rdy_c[win_idx] = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (rdy_c[i]) begin
                reg_addr_d  = bus.req_addr_in[i*RADDR_BITS +: RADDR_BITS];
                reg_wdata_d = bus.req_data_in[i*32 +: 32];
            end
        end
        reg_en_d = win_found;
        grant_d  = rdy_c;
    end

    // State and output registers; synchronous reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
            reg_en_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            reg_en_q    <= reg_en_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            grant_q     <= grant_d;
        end
    end

    assign bus.req_rdy_out   = rdy_c;
    assign bus.reg_en_out    = reg_en_q;
    assign bus.reg_addr_out  = reg_addr_q;
    assign bus.reg_wdata_out = reg_wdata_q;
    assign bus.grant_out     = grant_q;

`ifdef REG_ARB_WAIT_CNT_EN
    logic [NUM_REQ-1:0][15:0] wait_cnt_q, wait_cnt_d;

    // Saturating count of cycles each requester spends valid but not accepted.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (rdy_c[i]) begin
                wait_cnt_d[i] = '0;
            end else if (bus.req_vld_in[i] && wait_cnt_q[i] != 16'hffff) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 16'd1;
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt_out = wait_cnt_q;
`else
    assign wait_cnt_out = '0;
`endif

endmodule

// File: tb/tb_hssl_reg_wr_arbiter.sv
// Self-checking bench for hssl_reg_wr_arbiter (NUM_REQ=4, RADDR_BITS=8, MAX_BURST=4).
module tb_hssl_reg_wr_arbiter;
    localparam int N  = 4;
    localparam int RB = 8;
    localparam int MB = 4;

    typedef struct {
        logic [RB-1:0] addr;
        logic [31:0]   data;
        logic [N-1:0]  grant;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stop = 1'b0;
    logic [N*16-1:0] wait_cnt;

    int vectors = 0;
    int miscompares = 0;

    txn_t exp_q[$];

    hssl_reg_wr_arbiter_if #(.NUM_REQ(N), .RADDR_BITS(RB)) bus ();

    hssl_reg_wr_arbiter #(.NUM_REQ(N), .RADDR_BITS(RB), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .stop_in      (stop),
        .bus          (bus),
        .wait_cnt_out (wait_cnt)
    );

    always #5 clk = ~clk;

    // Reference arbiter state (value it will hold after the coming edge).
    int           m_busy = 0, m_owner = 0, m_cnt = 0, m_ptr = 0, m_cand;
    logic [N-1:0] m_rdy;
    logic [N-1:0] last_rdy = '0;
    txn_t         m_t;

    always @(negedge clk) begin
        m_rdy  = '0;
        m_cand = -1;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        end else if (stop) begin
            m_busy = 0; m_cnt = 0;
        end else begin
            if (m_busy != 0 && bus.req_vld_in[m_owner] && m_cnt < MB - 1) begin
                m_cand = m_owner;
                m_cnt  = m_cnt + 1;
            end else begin
                if (m_busy != 0) m_ptr = (m_owner + 1) % N;
                for (int k = 0; k < N; k++)
                    if (m_cand < 0 && bus.req_vld_in[(m_ptr + k) % N]) m_cand = (m_ptr + k) % N;
                if (m_cand >= 0) begin
                    m_busy = 1; m_owner = m_cand; m_cnt = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
        if (m_cand >= 0) m_rdy[m_cand] = 1'b1;
        vectors++;
        if (bus.req_rdy_out !== m_rdy) begin
            miscompares++;
            $display("FAIL model_rdy t=%0t got=%b want=%b", $time, bus.req_rdy_out, m_rdy);
        end
        if (m_cand >= 0) begin
            m_t.addr  = bus.req_addr_in[m_cand*RB +: RB];
            m_t.data  = bus.req_data_in[m_cand*32 +: 32];
            m_t.grant = m_rdy;
            exp_q.push_back(m_t);
        end
        last_rdy = m_rdy;
    end

    // Scoreboard: each accept must show up on the write port exactly one edge later.
    logic rst_at_edge;
    txn_t s_t;
    always @(posedge clk) begin
        rst_at_edge = reset;
        #1;
        vectors++;
        if (rst_at_edge) begin
            exp_q.delete();
            if (bus.reg_en_out !== 1'b0 || bus.grant_out !== '0 ||
                bus.reg_addr_out !== '0 || bus.reg_wdata_out !== '0) begin
                miscompares++;
                $display("FAIL sb_reset t=%0t en=%b grant=%b addr=%h data=%h want all 0",
                         $time, bus.reg_en_out, bus.grant_out, bus.reg_addr_out, bus.reg_wdata_out);
            end
        end else if (exp_q.size() > 0) begin
            s_t = exp_q.pop_front();
            if (bus.reg_en_out !== 1'b1 || bus.grant_out !== s_t.grant ||
                bus.reg_addr_out !== s_t.addr || bus.reg_wdata_out !== s_t.data) begin
                miscompares++;
                $display("FAIL sb_write t=%0t en=%b grant=%b addr=%h data=%h want en=1 grant=%b addr=%h data=%h",
                         $time, bus.reg_en_out, bus.grant_out, bus.reg_addr_out, bus.reg_wdata_out,
                         s_t.grant, s_t.addr, s_t.data);
            end
        end else if (bus.reg_en_out !== 1'b0 || bus.grant_out !== '0) begin
            miscompares++;
            $display("FAIL sb_idle t=%0t en=%b grant=%b want en=0 grant=0",
                     $time, bus.reg_en_out, bus.grant_out);
        end
    end

    // Advance to the input-drive slot of the next cycle.
    task automatic next_drive();
        @(posedge clk);
        #2;
    endtask

    task automatic sample_rdy();
        @(negedge clk);
        #1;
    endtask

    task automatic set_payloads();
        for (int i = 0; i < N; i++) begin
            bus.req_addr_in[i*RB +: RB] = RB'(8'h40 + i);
            bus.req_data_in[i*32 +: 32] = 32'ha000_0000 + 32'(i);
        end
    endtask

    task automatic apply_reset();
        next_drive();
        reset = 1'b1;
        stop  = 1'b0;
        bus.req_vld_in = '0;
        next_drive();
        next_drive();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_vld_in = '1;
        set_payloads();
        sample_rdy();
        vectors++;
        if (bus.req_rdy_out !== '0) begin
            miscompares++;
            $display("FAIL reset_rdy got=%b want=0000", bus.req_rdy_out);
        end
        next_drive();
        vectors++;
        if (bus.reg_en_out !== 1'b0 || bus.grant_out !== '0 || bus.reg_addr_out !== '0 ||
            bus.reg_wdata_out !== '0 || wait_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_outs en=%b grant=%b addr=%h data=%h wait=%h want all 0",
                     bus.reg_en_out, bus.grant_out, bus.reg_addr_out, bus.reg_wdata_out, wait_cnt);
        end
        bus.req_vld_in = '0;
    endtask

    task automatic test_single();
        apply_reset();
        bus.req_addr_in[1*RB +: RB] = 8'h12;
        bus.req_data_in[1*32 +: 32] = 32'hdeadbeef;
        bus.req_vld_in = 4'b0010;
        sample_rdy();
        vectors++;
        if (bus.req_rdy_out !== 4'b0010) begin
            miscompares++;
            $display("FAIL single_rdy got=%b want=0010", bus.req_rdy_out);
        end
        next_drive();
        bus.req_vld_in = '0;
        vectors++;
        if (bus.reg_en_out !== 1'b1 || bus.reg_addr_out !== 8'h12 ||
            bus.reg_wdata_out !== 32'hdeadbeef || bus.grant_out !== 4'b0010) begin
            miscompares++;
            $display("FAIL single_write en=%b addr=%h data=%h grant=%b want 1/12/deadbeef/0010",
                     bus.reg_en_out, bus.reg_addr_out, bus.reg_wdata_out, bus.grant_out);
        end
        next_drive();
        vectors++;
        if (bus.reg_en_out !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pulse en=%b want 0", bus.reg_en_out);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        apply_reset();
        set_payloads();
        bus.req_vld_in = '1;
        for (int k = 0; k < 20; k++) begin
            next_drive();
            eg = '0;
            eg[(k / MB) % N] = 1'b1;
            vectors++;
            if (bus.grant_out !== eg || bus.reg_en_out !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_order k=%0d grant=%b en=%b want grant=%b en=1",
                         k, bus.grant_out, bus.reg_en_out, eg);
            end
        end
        bus.req_vld_in = '0;
    endtask

    task automatic test_drop();
        apply_reset();
        set_payloads();
        bus.req_vld_in = 4'b0101;
        next_drive();
        next_drive();
        bus.req_vld_in[0] = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            if (c == 3) bus.req_vld_in[1] = 1'b1;
            sample_rdy();
            vectors++;
            if (bus.req_rdy_out !== 4'b0100) begin
                miscompares++;
                $display("FAIL drop_burst c=%0d got=%b want=0100", c, bus.req_rdy_out);
            end
            next_drive();
        end
        sample_rdy();
        vectors++;
        if (bus.req_rdy_out !== 4'b0010) begin
            miscompares++;
            $display("FAIL drop_handover got=%b want=0010", bus.req_rdy_out);
        end
        next_drive();
        bus.req_vld_in = '0;
    endtask

    task automatic test_stop();
        apply_reset();
        set_payloads();
        bus.req_vld_in = 4'b1000;
        sample_rdy();
        vectors++;
        if (bus.req_rdy_out !== 4'b1000) begin
            miscompares++;
            $display("FAIL stop_first got=%b want=1000", bus.req_rdy_out);
        end
        next_drive();
        stop = 1'b1;
        vectors++;
        if (bus.reg_en_out !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_inflight en=%b want 1", bus.reg_en_out);
        end
        for (int c = 1; c <= 5; c++) begin
            sample_rdy();
            vectors++;
            if (bus.req_rdy_out !== '0) begin
                miscompares++;
                $display("FAIL stop_rdy c=%0d got=%b want=0000", c, bus.req_rdy_out);
            end
            next_drive();
            vectors++;
            if (bus.reg_en_out !== 1'b0) begin
                miscompares++;
                $display("FAIL stop_en c=%0d en=%b want 0", c, bus.reg_en_out);
            end
        end
        stop = 1'b0;
        sample_rdy();
        vectors++;
        if (bus.req_rdy_out !== 4'b1000) begin
            miscompares++;
            $display("FAIL stop_release got=%b want=1000", bus.req_rdy_out);
        end
        next_drive();
        bus.req_vld_in = '0;
        vectors++;
        if (bus.reg_en_out !== 1'b1 || bus.grant_out !== 4'b1000) begin
            miscompares++;
            $display("FAIL stop_release_wr en=%b grant=%b want 1/1000", bus.reg_en_out, bus.grant_out);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        set_payloads();
        bus.req_vld_in = '1;
        next_drive();
        next_drive();
        reset = 1'b1;
        vectors++;
        if (bus.reg_en_out !== 1'b1 || bus.grant_out !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_before en=%b grant=%b want 1/0001", bus.reg_en_out, bus.grant_out);
        end
        sample_rdy();
        vectors++;
        if (bus.req_rdy_out !== '0) begin
            miscompares++;
            $display("FAIL midrst_rdy got=%b want=0000", bus.req_rdy_out);
        end
        next_drive();
        vectors++;
        if (bus.reg_en_out !== 1'b0 || bus.grant_out !== '0 ||
            bus.reg_addr_out !== '0 || bus.reg_wdata_out !== '0) begin
            miscompares++;
            $display("FAIL midrst_drop en=%b grant=%b addr=%h data=%h want all 0",
                     bus.reg_en_out, bus.grant_out, bus.reg_addr_out, bus.reg_wdata_out);
        end
        reset = 1'b0;
        sample_rdy();
        vectors++;
        if (bus.req_rdy_out !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_first got=%b want=0001", bus.req_rdy_out);
        end
        next_drive();
        bus.req_vld_in = '0;
    endtask

    task automatic test_wait_cnt();
        apply_reset();
        set_payloads();
`ifdef REG_ARB_WAIT_CNT_EN
        stop = 1'b1;
        bus.req_vld_in = 4'b0011;
        for (int c = 0; c < 6; c++) next_drive();
        stop = 1'b0;
        for (int c = 6; c < 10; c++) next_drive();
        sample_rdy();
        vectors++;
        if (bus.req_rdy_out !== 4'b0010 || wait_cnt[1*16 +: 16] !== 16'd10) begin
            miscompares++;
            $display("FAIL wait_at_grant rdy=%b wait1=%0d want 0010/10",
                     bus.req_rdy_out, wait_cnt[1*16 +: 16]);
        end
        next_drive();
        bus.req_vld_in = '0;
        vectors++;
        if (wait_cnt[1*16 +: 16] !== 16'd0) begin
            miscompares++;
            $display("FAIL wait_clear wait1=%0d want 0", wait_cnt[1*16 +: 16]);
        end
        apply_reset();
        stop = 1'b1;
        bus.req_vld_in = 4'b0100;
        for (int c = 0; c < 70000; c++) next_drive();
        vectors++;
        if (wait_cnt[2*16 +: 16] !== 16'hffff) begin
            miscompares++;
            $display("FAIL wait_sat wait2=%h want ffff", wait_cnt[2*16 +: 16]);
        end
        stop = 1'b0;
        next_drive();
        bus.req_vld_in = '0;
        vectors++;
        if (wait_cnt[2*16 +: 16] !== 16'd0) begin
            miscompares++;
            $display("FAIL wait_sat_clear wait2=%h want 0", wait_cnt[2*16 +: 16]);
        end
`else
        stop = 1'b1;
        bus.req_vld_in = '1;
        for (int c = 0; c < 5; c++) begin
            next_drive();
            vectors++;
            if (wait_cnt !== '0) begin
                miscompares++;
                $display("FAIL wait_tied c=%0d wait=%h want 0", c, wait_cnt);
            end
        end
        stop = 1'b0;
        bus.req_vld_in = '0;
`endif
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            stop = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(bus.req_vld_in[i] && !last_rdy[i])) begin
                    bus.req_vld_in[i] = ($urandom_range(0, 3) != 0);
                    bus.req_addr_in[i*RB +: RB] = RB'($urandom);
                    bus.req_data_in[i*32 +: 32] = $urandom;
                end
            end
            next_drive();
        end
        stop = 1'b0;
        bus.req_vld_in = '0;
        next_drive();
        next_drive();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain left=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        bus.req_vld_in  = '0;
        bus.req_addr_in = '0;
        bus.req_data_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_stop();
        test_reset_mid_burst();
        test_wait_cnt();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
